// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using one double-dabble step per clock.
// Accepts signed or unsigned input and reports sign and decimal overflow.
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      binary,
    input  logic                  signed_mode,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  negative,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic             sign_q, sign_d;
    logic [BW-1:0]    scr_q, scr_d;
    logic             sticky_q, sticky_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;

    logic             neg_in;
    logic [WIDTH-1:0] mag_in;
    logic [BW-1:0]    adj;
    logic [BW-1:0]    scr_next;
    logic             carry;

    // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude.
    assign neg_in = signed_mode & binary[WIDTH-1];
    assign mag_in = neg_in ? -binary : binary;

    always_comb begin
        adj = scr_q;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (adj[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
            end
        end
        carry    = adj[BW-1];
        scr_next = {adj[BW-2:0], mag_q[WIDTH-1]};
    end

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        sign_d   = sign_q;
        scr_d    = scr_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mag_d    = mag_in;
                    sign_d   = neg_in & (|mag_in);
                    scr_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                scr_d    = scr_next;
                mag_d    = {mag_q[WIDTH-2:0], 1'b0};
                sticky_d = sticky_q | carry;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    bcd_d   = scr_next;
                    neg_d   = sign_q;
                    ovf_d   = sticky_q | carry;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mag_q    <= '0;
            sign_q   <= 1'b0;
            scr_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            sign_q   <= sign_d;
            scr_q    <= scr_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);
    assign bcd      = bcd_q;
    assign negative = neg_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and randomised checks of bin2bcd_seq at three WIDTH/DIGITS settings
// sharing one stimulus stream.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] binary;
    logic        signed_mode;
    logic [7:0]  bin8;

    logic        busy5, done5, neg5, ovf5;
    logic [19:0] bcd5;
    logic        busy4, done4, neg4, ovf4;
    logic [15:0] bcd4;
    logic        busy8, done8, neg8, ovf8;
    logic [7:0]  bcd8;

    int n_assert;
    int n_fail;

    assign bin8 = binary[7:0];

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut5 (
        .clk(clk), .rst(rst), .start(start), .binary(binary), .signed_mode(signed_mode),
        .busy(busy5), .done(done5), .bcd(bcd5), .negative(neg5), .overflow(ovf5)
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .binary(binary), .signed_mode(signed_mode),
        .busy(busy4), .done(done4), .bcd(bcd4), .negative(neg4), .overflow(ovf4)
    );

    bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .binary(bin8), .signed_mode(signed_mode),
        .busy(busy8), .done(done8), .bcd(bcd8), .negative(neg8), .overflow(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned p10(input int d);
        longint unsigned r = 1;
        for (int i = 0; i < d; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [39:0] to_bcd(input longint unsigned mag, input int digits);
        logic [39:0] r = '0;
        longint unsigned v = mag;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic longint unsigned mag_of(input longint unsigned raw, input int w, input logic sm);
        longint unsigned lim = 64'd1 << w;
        if (sm && raw[w-1]) return lim - raw;
        return raw;
    endfunction

    // Waits out any DONE cycle, starts a conversion, and checks handshake timing.
    task automatic run_conv(input logic [15:0] val, input logic sm);
        int lat;
        lat = 0;
        @(posedge clk);
        @(negedge clk);
        binary      = val;
        signed_mode = sm;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", 40'(busy5), 40'd1);
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done5) break;
        end
        check("latency", 40'(lat), 40'd16);
        check("done4_aligned", 40'(done4), 40'd1);
        check("busy_in_done", 40'(busy5), 40'd0);
    endtask

    initial begin
        int pulses;
        logic [15:0] v;
        logic sm;
        longint unsigned m16, m8;

        n_assert    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        start       = 1'b0;
        binary      = '0;
        signed_mode = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 40'(busy5), 40'd0);
        check("rst_done", 40'(done5), 40'd0);
        check("rst_bcd", 40'(bcd5), 40'd0);
        check("rst_neg", 40'(neg5), 40'd0);
        check("rst_ovf", 40'(ovf5), 40'd0);
        @(negedge clk);
        rst = 1'b0;

        // 65535 unsigned
        run_conv(16'd65535, 1'b0);
        check("u65535_bcd", 40'(bcd5), 40'h65535);
        check("u65535_neg", 40'(neg5), 40'd0);
        check("u65535_ovf", 40'(ovf5), 40'd0);
        check("u65535_bcd4", 40'(bcd4), 40'h5535);
        check("u65535_ovf4", 40'(ovf4), 40'd1);
        check("u255_bcd8", 40'(bcd8), 40'h55);
        check("u255_ovf8", 40'(ovf8), 40'd1);

        // -1 signed
        run_conv(16'hFFFF, 1'b1);
        check("sm1_bcd", 40'(bcd5), 40'h00001);
        check("sm1_neg", 40'(neg5), 40'd1);
        check("sm1_ovf", 40'(ovf5), 40'd0);
        check("sm1_bcd8", 40'(bcd8), 40'h01);
        check("sm1_neg8", 40'(neg8), 40'd1);

        // Most negative value
        run_conv(16'h8000, 1'b1);
        check("smin_bcd", 40'(bcd5), 40'h32768);
        check("smin_neg", 40'(neg5), 40'd1);
        check("smin_bcd4", 40'(bcd4), 40'h2768);
        check("smin_ovf4", 40'(ovf4), 40'd1);
        check("smin_neg8", 40'(neg8), 40'd0);

        // Four-digit overflow, then a value that fits
        run_conv(16'd12345, 1'b0);
        check("d4_12345_bcd", 40'(bcd4), 40'h2345);
        check("d4_12345_ovf", 40'(ovf4), 40'd1);
        check("d5_12345_bcd", 40'(bcd5), 40'h12345);
        run_conv(16'd42, 1'b0);
        check("d4_42_bcd", 40'(bcd4), 40'h0042);
        check("d4_42_ovf", 40'(ovf4), 40'd0);

        // start held high through the conversion
        @(posedge clk);
        @(negedge clk);
        binary      = 16'd1234;
        signed_mode = 1'b0;
        start       = 1'b1;
        @(negedge clk);
        binary = 16'd9999;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done5) pulses++;
        end
        @(posedge clk);
        #1;
        check("hold_done_at16", 40'(done5), 40'd1);
        check("hold_early_pulses", 40'(pulses), 40'd0);
        check("hold_bcd", 40'(bcd5), 40'h01234);
        @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done5) pulses++;
        end
        check("hold_no_second_done", 40'(pulses), 40'd0);
        check("hold_bcd_kept", 40'(bcd5), 40'h01234);

        // Reset in the middle of a conversion
        @(negedge clk);
        binary      = 16'hFFFF;
        signed_mode = 1'b1;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", 40'(busy5), 40'd0);
        check("mid_rst_done", 40'(done5), 40'd0);
        check("mid_rst_bcd", 40'(bcd5), 40'd0);
        check("mid_rst_neg", 40'(neg5), 40'd0);
        check("mid_rst_ovf", 40'(ovf5), 40'd0);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done5) pulses++;
        end
        check("mid_rst_no_done", 40'(pulses), 40'd0);
        check("mid_rst_bcd_held", 40'(bcd5), 40'd0);
        run_conv(16'd0, 1'b1);
        check("zero_bcd", 40'(bcd5), 40'd0);
        check("zero_neg", 40'(neg5), 40'd0);

        // Randomised sweep
        for (int n = 0; n < 1000; n++) begin
            v  = 16'($urandom_range(0, 65535));
            sm = 1'($urandom_range(0, 1));
            run_conv(v, sm);
            m16 = mag_of(longint'(v), 16, sm);
            m8  = mag_of(longint'(v[7:0]), 8, sm);
            check("rnd_bcd5", 40'(bcd5), to_bcd(m16, 5));
            check("rnd_ovf5", 40'(ovf5), 40'(m16 >= p10(5)));
            check("rnd_neg5", 40'(neg5), 40'(sm & v[15]));
            check("rnd_bcd4", 40'(bcd4), to_bcd(m16, 4));
            check("rnd_ovf4", 40'(ovf4), 40'(m16 >= p10(4)));
            check("rnd_bcd8", 40'(bcd8), to_bcd(m8, 2));
            check("rnd_ovf8", 40'(ovf8), 40'(m8 >= p10(2)));
            check("rnd_neg8", 40'(neg8), 40'(sm & v[7]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
